// File: rtl/paula_disk_fifo.sv
// Paula disk word FIFO: buffers MFM words between the disk shifter and Agnus DMA,
// owns DSKLEN (double-write arming, word countdown) and raises the DSKBLK pulse.
module paula_disk_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        dmal,
  output logic        dmas,
  input  logic [15:0] disk_rx_data,
  input  logic        disk_rx_valid,
  output logic [15:0] disk_tx_data,
  output logic        disk_tx_ready,
  input  logic        disk_tx_ack,
  output logic        blckint,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [8:1] ADDR_DSKLEN  = 8'h12;
  localparam logic [8:1] ADDR_DSKDAT  = 8'h13;
  localparam logic [8:1] ADDR_DSKDATR = 8'h04;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  arm_q, arm_d;
  logic                  dmas_q, dmas_d;
  logic                  ovf_q, ovf_d;
  logic [13:0]           rem_q, rem_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [15:0]           mem_q [DEPTH];

  logic        st_active, st_drain;
  logic        empty, full, rem_nz;
  logic        dsklen_wr, abort, start;
  logic        rd_pop, wr_pop, pop;
  logic        rd_push_req, wr_push_req, push;
  logic        ovf_set, dec;
  logic [13:0] rem_after;
  logic [DEPTH_LOG2:0] count_after;
  logic [15:0] head, push_data;

  assign st_active = (state_q == ST_ACTIVE);
  assign st_drain  = (state_q == ST_DRAIN);
  assign empty     = (count_q == '0);
  assign full      = count_q[DEPTH_LOG2];
  assign rem_nz    = (rem_q != '0);

  assign dsklen_wr = clk7_en && (reg_address_in == ADDR_DSKLEN);
  assign abort     = dsklen_wr && !data_in[15];
  assign start     = dsklen_wr && data_in[15] && arm_q;

  assign rd_pop = clk7_en && !dmas_q && st_active && (reg_address_in == ADDR_DSKDATR) && !empty;
  assign wr_pop = clk7_en && dmas_q && (st_active || st_drain) && disk_tx_ack && !empty;
  assign pop    = rd_pop || wr_pop;

  // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
  assign rd_push_req = clk7_en && !dmas_q && st_active && disk_rx_valid;
  assign wr_push_req = clk7_en && dmas_q && st_active && (reg_address_in == ADDR_DSKDAT) && rem_nz;
  assign push        = (rd_push_req || wr_push_req) && (!full || pop);
  assign ovf_set     = rd_push_req && full && !pop;
  assign push_data   = dmas_q ? data_in : disk_rx_data;

  assign dec       = (rd_pop && rem_nz) || (wr_push_req && push);
  assign rem_after = dec ? (rem_q - 14'd1) : rem_q;

  always_comb begin
    count_after = count_q;
    if (push && !pop)      count_after = count_q + CNT_ONE;
    else if (pop && !push) count_after = count_q - CNT_ONE;
  end

  always_comb begin
    state_d  = state_q;
    arm_d    = arm_q;
    dmas_d   = dmas_q;
    ovf_d    = ovf_q || ovf_set;
    rem_d    = rem_after;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_after;

    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_ACTIVE: if (rem_after == '0) state_d = dmas_q ? ST_DRAIN : ST_DONE;
      ST_DRAIN:  if (count_after == '0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Arming needs two DMAEN writes; the flag stays set until a DMAEN=0 write.
    if (dsklen_wr && data_in[15]) begin
      if (!arm_q) begin
        arm_d = 1'b1;
      end else begin
        dmas_d  = data_in[14];
        rem_d   = data_in[13:0];
        state_d = ST_ACTIVE;
      end
    end

    if (abort) begin
      state_d  = ST_IDLE;
      arm_d    = 1'b0;
      ovf_d    = 1'b0;
      rem_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      arm_q    <= 1'b0;
      dmas_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clk7_en) begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      dmas_q   <= dmas_d;
      ovf_q    <= ovf_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Storage is not reset, so an empty FIFO presents zero rather than a stale word.
  assign head = empty ? 16'h0000 : mem_q[rd_ptr_q];

  assign data_out      = (reg_address_in == ADDR_DSKDATR) ? head : 16'h0000;
  assign disk_tx_data  = head;
  assign disk_tx_ready = dmas_q && (st_active || st_drain) && !empty;
  assign dmal          = st_active && rem_nz && (dmas_q ? !full : !empty);
  assign dmas          = dmas_q;
  assign blckint       = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign overflow      = ovf_q;
  assign dbg_state_o   = state_q;

endmodule
